music_play_ctrl: RTL and testbench
==================================

Name: music_play_ctrl

Overview:
- Playback sequencer for the music play circuit.
- Consumes one-cycle debounced key pulses from the column-key scanner and runs a play/pause/stop state machine.
- Selects the song, advances the note ROM address on a programmable beat tick, and gates the tone generator.
- Sits between the key scanner and the song ROM / tone divider.

Parameters:
- NUM_SONGS, 4, number of songs; song_sel wraps in 0..NUM_SONGS-1 (2..2**SONG_W).
- SONG_W, 2, width of song_sel.
- NOTE_W, 6, width of note_addr; max song length is 2**NOTE_W notes.
- BEAT_DIV, 6_250_000, clk cycles per note (0.25 s at 25 MHz); must be >= 2.

Ports:
- clk  input  1  system clock, 25 MHz.
- rst  input  1  synchronous reset, active-high.
- key_pulse  input  4  one-cycle key-press pulses, active-high. Bit0 play/pause, bit1 next, bit2 prev, bit3 stop.
- note_end  input  1  song ROM flags the word at the current song_sel/note_addr as the end-of-song marker.
- song_sel  output  SONG_W  current song index.
- note_addr  output  NOTE_W  current note index within the song.
- tone_en  output  1  tone generator enable; high only in PLAY.
- play_state  output  2  state code: 0 IDLE, 1 PLAY, 2 PAUSE.
- beat_tick  output  1  one-cycle pulse on each note advance.

Behaviour:
- Reset: rst high at a clk edge forces IDLE, song_sel=0, note_addr=0, beat counter=0, tone_en=0, beat_tick=0. Reset mid-song aborts immediately; no key is remembered.
- All outputs are registered. A key pulse sampled at edge N takes effect at the outputs after edge N (one-cycle latency).
- Key priority when several bits are high in one cycle: stop > play/pause > next > prev. Only the highest-priority key acts; the rest are dropped.
- State machine:
  - IDLE + play/pause -> PLAY; note_addr=0, beat counter=0.
  - PLAY + play/pause -> PAUSE; note_addr and beat counter are held.
  - PAUSE + play/pause -> PLAY; resumes from the held note and count.
  - Any state + stop -> IDLE; note_addr=0, beat counter=0, song_sel kept.
  - next: song_sel = (song_sel==NUM_SONGS-1) ? 0 : song_sel+1.
  - prev: song_sel = (song_sel==0) ? NUM_SONGS-1 : song_sel-1.
  - next/prev in any state also clear note_addr and the beat counter; play_state is unchanged.
- Beat counter:
  - Counts 0..BEAT_DIV-1, only in PLAY.
  - At count BEAT_DIV-1: wraps to 0, beat_tick=1 for one cycle, note step applied.
  - Held in IDLE/PAUSE.
- Note step, evaluated on the tick cycle:
  - If note_end=1 or note_addr==2**NOTE_W-1: end-of-song (see Optional Feature).
  - Otherwise note_addr+1.
- note_end is sampled only on tick cycles; it is ignored otherwise.
- Simultaneous key and tick: the key action wins and the note step is discarded that cycle. beat_tick still pulses.
- tone_en = (play_state==PLAY), registered, so it updates on the same edge as play_state.
- play_state code 3 is unreachable. If reached, the next edge goes to IDLE.

Optional Feature:
- Macro: AUTO_NEXT_EN.
- Defined: at end-of-song, song_sel advances with the same wrap as next, note_addr=0, and the block stays in PLAY.
- Undefined: at end-of-song, the block goes to IDLE, note_addr=0, song_sel is unchanged, and tone_en drops on the same edge.

Test Plan:
- BEAT_DIV=4, rst 3 cycles -> all outputs 0. Pulse bit0 -> play_state=1, tone_en=1 next cycle; beat_tick every 4 cycles; note_addr 0,1,2,...
- In PLAY at note_addr=5, pulse bit0 -> PAUSE, note_addr stays 5 for 20 cycles. Pulse bit0 again -> PLAY, first tick after the remaining count gives note_addr=6.
- song_sel=3, NUM_SONGS=4, pulse bit1 -> song_sel=0, note_addr=0. Then pulse bit2 -> song_sel=3.
- Pulse key_pulse=4'b1111 during PLAY -> stop wins: IDLE, note_addr=0, song_sel unchanged.
- Drive note_end=1 at note_addr=9 on a tick. Without AUTO_NEXT_EN -> IDLE, tone_en=0, song_sel same. With it -> song_sel+1, note_addr=0, still PLAY.
- Assert rst in PAUSE at song_sel=2, note_addr=7 -> next edge all outputs 0. Check that a bit1 pulse arriving together with a tick cycle changes the song and does not advance the note.

Source files
------------

// File: rtl/music_play_ctrl_if.sv
// Key-scanner / song-ROM side bundle of the playback sequencer.
// Purely combinational wiring; no latency of its own.
// No backpressure: key pulses and note_end are sampled every cycle.
interface music_play_ctrl_if #(
  parameter int SONG_W = 2,
  parameter int NOTE_W = 6
);
  logic [3:0]        key_pulse;   // bit0 play/pause, bit1 next, bit2 prev, bit3 stop
  logic              note_end;    // end-of-song marker at song_sel/note_addr
  logic [SONG_W-1:0] song_sel;
  logic [NOTE_W-1:0] note_addr;
  logic              tone_en;
  logic [1:0]        play_state;  // 0 IDLE, 1 PLAY, 2 PAUSE
  logic              beat_tick;

  // Sequencer side: takes keys and ROM flag, drives ROM address and tone gate.
  modport master (
    input  key_pulse, note_end,
    output song_sel, note_addr, tone_en, play_state, beat_tick
  );

  // Scanner / ROM / tone divider side.
  modport slave (
    output key_pulse, note_end,
    input  song_sel, note_addr, tone_en, play_state, beat_tick
  );
endinterface

// File: rtl/music_play_ctrl.sv
// Play/pause/stop sequencer: song select, note address stepping on a beat tick, tone gate.
// Latency: one cycle from key pulse or beat wrap to registered outputs.
// No backpressure: every key pulse is acted on or dropped by priority. Option: AUTO_NEXT_EN.
module music_play_ctrl #(
  parameter int NUM_SONGS = 4,
  parameter int SONG_W    = 2,
  parameter int NOTE_W    = 6,
  parameter int BEAT_DIV  = 6_250_000
) (
  input  logic                 clk,
  input  logic                 rst,
  music_play_ctrl_if.master    bus
);

  localparam int CNT_W = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(BEAT_DIV - 1);
  localparam logic [SONG_W-1:0] SONG_MAX = SONG_W'(NUM_SONGS - 1);
  localparam logic [NOTE_W-1:0] NOTE_MAX = '1;

  // Elaboration-time sanity on the configuration.
  if (BEAT_DIV < 2) begin : g_bad_div
    $error("music_play_ctrl: BEAT_DIV must be >= 2");
  end
  if (NUM_SONGS < 2 || NUM_SONGS > (1 << SONG_W)) begin : g_bad_songs
    $error("music_play_ctrl: NUM_SONGS must lie in 2..2**SONG_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [SONG_W-1:0] song, song_nxt;
  logic [NOTE_W-1:0] note, note_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              tick, tick_nxt;
  logic              tone, tone_nxt;

  // Priority-decoded keys: stop > play/pause > next > prev.
  logic k_stop, k_play, k_next, k_prev;
  logic tick_now;
  logic song_end;
  logic [SONG_W-1:0] song_inc, song_dec;

  // Key priority decode and the shared wrap arithmetic.
  always_comb begin
    k_stop   = bus.key_pulse[3];
    k_play   = bus.key_pulse[0] & ~bus.key_pulse[3];
    k_next   = bus.key_pulse[1] & ~bus.key_pulse[3] & ~bus.key_pulse[0];
    k_prev   = bus.key_pulse[2] & ~bus.key_pulse[3] & ~bus.key_pulse[0] & ~bus.key_pulse[1];
    tick_now = (state == ST_PLAY) && (cnt == CNT_MAX);
    // note_end only matters on a tick cycle; it is gated by tick_now below.
    song_end = bus.note_end || (note == NOTE_MAX);
    song_inc = (song == SONG_MAX) ? '0 : song + 1'b1;
    song_dec = (song == '0) ? SONG_MAX : song - 1'b1;
  end

  // Next-state logic: beat counter first, then key actions override it,
  // and only with no key does the tick step the note.
  always_comb begin
    state_nxt = state;
    song_nxt  = song;
    note_nxt  = note;
    cnt_nxt   = cnt;
    tick_nxt  = 1'b0;

    if (state == ST_PLAY) begin
      cnt_nxt  = tick_now ? '0 : cnt + 1'b1;
      tick_nxt = tick_now;
    end

    case (state)
      ST_IDLE, ST_PLAY, ST_PAUSE: begin
        if (k_stop) begin
          state_nxt = ST_IDLE;
          note_nxt  = '0;
          cnt_nxt   = '0;
        end else if (k_play) begin
          case (state)
            ST_IDLE: begin
              state_nxt = ST_PLAY;
              note_nxt  = '0;
              cnt_nxt   = '0;
            end
            ST_PLAY: begin
              // Pause freezes position; a tick landing here is consumed.
              state_nxt = ST_PAUSE;
              cnt_nxt   = tick_now ? '0 : cnt;
            end
            default: begin
              state_nxt = ST_PLAY;
            end
          endcase
        end else if (k_next || k_prev) begin
          song_nxt = k_next ? song_inc : song_dec;
          note_nxt = '0;
          cnt_nxt  = '0;
        end else if (tick_now) begin
          if (song_end) begin
            note_nxt = '0;
`ifdef AUTO_NEXT_EN
            song_nxt = song_inc;
`else
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
`endif
          end else begin
            note_nxt = note + 1'b1;
          end
        end
      end
      default: begin
        // Unreachable code 3: fall back to a clean IDLE.
        state_nxt = ST_IDLE;
        note_nxt  = '0;
        cnt_nxt   = '0;
        tick_nxt  = 1'b0;
      end
    endcase

    tone_nxt = (state_nxt == ST_PLAY);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      song  <= '0;
      note  <= '0;
      cnt   <= '0;
      tick  <= 1'b0;
      tone  <= 1'b0;
    end else begin
      state <= state_nxt;
      song  <= song_nxt;
      note  <= note_nxt;
      cnt   <= cnt_nxt;
      tick  <= tick_nxt;
      tone  <= tone_nxt;
    end
  end

  assign bus.song_sel   = song;
  assign bus.note_addr  = note;
  assign bus.tone_en    = tone;
  assign bus.play_state = state;
  assign bus.beat_tick  = tick;

endmodule

// File: tb/tb_music_play_ctrl.sv
// Directed bench for music_play_ctrl with BEAT_DIV=4, NUM_SONGS=4.
// Outputs sampled 1 time unit after each rising edge.
// Table of per-edge vectors followed by multi-cycle hand sequences.
module tb_music_play_ctrl;

  logic clk;
  logic rst;

  music_play_ctrl_if #(.SONG_W(2), .NOTE_W(6)) bus ();

  music_play_ctrl #(
    .NUM_SONGS(4),
    .SONG_W   (2),
    .NOTE_W   (6),
    .BEAT_DIV (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] key;
    logic       ne;
    logic       rs;
    logic [1:0] song;
    logic [5:0] note;
    logic       tone;
    logic [1:0] st;
    logic       tick;
  } vec_t;

  vec_t tbl[25];

  task automatic drive(input logic [3:0] k, input logic ne, input logic r);
    bus.key_pulse = k;
    bus.note_end  = ne;
    rst           = r;
    @(posedge clk);
    #1;
    bus.key_pulse = 4'd0;
    bus.note_end  = 1'b0;
    rst           = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(4'd0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [1:0] song, input logic [5:0] note,
                     input logic tone, input logic [1:0] st, input logic tick);
    checks++;
    if ({bus.song_sel, bus.note_addr, bus.tone_en, bus.play_state, bus.beat_tick} !==
        {song, note, tone, st, tick}) begin
      errors++;
      $display("FAIL %s: got song=%0d note=%0d tone=%0d state=%0d tick=%0d, expected song=%0d note=%0d tone=%0d state=%0d tick=%0d",
               name, bus.song_sel, bus.note_addr, bus.tone_en, bus.play_state, bus.beat_tick,
               song, note, tone, st, tick);
    end
  endtask

`ifdef AUTO_NEXT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  initial begin
    bus.key_pulse = 4'd0;
    bus.note_end  = 1'b0;
    rst           = 1'b1;

    //          key    ne    rst   song  note tone st    tick
    tbl[0]  = '{4'h0, 1'b0, 1'b1, 2'd0, 6'd0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'h0, 1'b0, 1'b1, 2'd0, 6'd0, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{4'h0, 1'b0, 1'b1, 2'd0, 6'd0, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{4'h0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 1'b0};
    tbl[4]  = '{4'h1, 1'b0, 1'b0, 2'd0, 6'd0, 1'b1, 2'd1, 1'b0}; // play
    tbl[5]  = '{4'h0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b1, 2'd1, 1'b0};
    tbl[6]  = '{4'h0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b1, 2'd1, 1'b0};
    tbl[7]  = '{4'h0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b1, 2'd1, 1'b0};
    tbl[8]  = '{4'h0, 1'b0, 1'b0, 2'd0, 6'd1, 1'b1, 2'd1, 1'b1}; // first tick
    tbl[9]  = '{4'h0, 1'b0, 1'b0, 2'd0, 6'd1, 1'b1, 2'd1, 1'b0};
    tbl[10] = '{4'h0, 1'b0, 1'b0, 2'd0, 6'd1, 1'b1, 2'd1, 1'b0};
    tbl[11] = '{4'h0, 1'b0, 1'b0, 2'd0, 6'd1, 1'b1, 2'd1, 1'b0};
    tbl[12] = '{4'h0, 1'b0, 1'b0, 2'd0, 6'd2, 1'b1, 2'd1, 1'b1};
    tbl[13] = '{4'h2, 1'b0, 1'b0, 2'd1, 6'd0, 1'b1, 2'd1, 1'b0}; // next
    tbl[14] = '{4'h4, 1'b0, 1'b0, 2'd0, 6'd0, 1'b1, 2'd1, 1'b0}; // prev
    tbl[15] = '{4'h4, 1'b0, 1'b0, 2'd3, 6'd0, 1'b1, 2'd1, 1'b0}; // prev wraps
    tbl[16] = '{4'h2, 1'b0, 1'b0, 2'd0, 6'd0, 1'b1, 2'd1, 1'b0}; // next wraps
    tbl[17] = '{4'h2, 1'b0, 1'b0, 2'd1, 6'd0, 1'b1, 2'd1, 1'b0};
    tbl[18] = '{4'h0, 1'b0, 1'b0, 2'd1, 6'd0, 1'b1, 2'd1, 1'b0};
    tbl[19] = '{4'h0, 1'b0, 1'b0, 2'd1, 6'd0, 1'b1, 2'd1, 1'b0};
    tbl[20] = '{4'h0, 1'b0, 1'b0, 2'd1, 6'd0, 1'b1, 2'd1, 1'b0};
    tbl[21] = '{4'h0, 1'b0, 1'b0, 2'd1, 6'd1, 1'b1, 2'd1, 1'b1};
    tbl[22] = '{4'hF, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0, 2'd0, 1'b0}; // all keys: stop wins
    tbl[23] = '{4'h0, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0, 2'd0, 1'b0};
    tbl[24] = '{4'h2, 1'b0, 1'b0, 2'd2, 6'd0, 1'b0, 2'd0, 1'b0}; // next in IDLE

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].key, tbl[i].ne, tbl[i].rs);
      chk($sformatf("vec%0d", i), tbl[i].song, tbl[i].note, tbl[i].tone, tbl[i].st, tbl[i].tick);
    end

    // Pause and resume from the held note and count.
    drive(4'h1, 1'b0, 1'b0);
    chk("play_song2", 2'd2, 6'd0, 1'b1, 2'd1, 1'b0);
    run(20);
    chk("reach_note5", 2'd2, 6'd5, 1'b1, 2'd1, 1'b1);
    run(2);
    drive(4'h1, 1'b0, 1'b0);
    chk("pause", 2'd2, 6'd5, 1'b0, 2'd2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(4'h0, 1'b0, 1'b0);
      chk($sformatf("pause_hold%0d", i), 2'd2, 6'd5, 1'b0, 2'd2, 1'b0);
    end
    drive(4'h1, 1'b0, 1'b0);
    chk("resume", 2'd2, 6'd5, 1'b1, 2'd1, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    chk("resume_cnt3", 2'd2, 6'd5, 1'b1, 2'd1, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    chk("resume_tick", 2'd2, 6'd6, 1'b1, 2'd1, 1'b1);

    // next arriving on a tick cycle: song changes, note not advanced, tick still pulses.
    run(3);
    drive(4'h2, 1'b0, 1'b0);
    chk("next_on_tick", 2'd3, 6'd0, 1'b1, 2'd1, 1'b1);

    // End-of-song via note_end at note 9; note_end off-tick is ignored.
    run(36);
    chk("reach_note9", 2'd3, 6'd9, 1'b1, 2'd1, 1'b1);
    drive(4'h0, 1'b1, 1'b0);
    chk("note_end_offtick", 2'd3, 6'd9, 1'b1, 2'd1, 1'b0);
    run(2);
    drive(4'h0, 1'b1, 1'b0);
    if (AUTO) chk("end_auto", 2'd0, 6'd0, 1'b1, 2'd1, 1'b1);
    else      chk("end_idle", 2'd3, 6'd0, 1'b0, 2'd0, 1'b1);

    // Reset from PAUSE at song 2 / note 7; a key coincident with reset is dropped.
    drive(4'h0, 1'b0, 1'b1);
    chk("rst_clear", 2'd0, 6'd0, 1'b0, 2'd0, 1'b0);
    drive(4'h2, 1'b0, 1'b0);
    drive(4'h2, 1'b0, 1'b0);
    chk("song2", 2'd2, 6'd0, 1'b0, 2'd0, 1'b0);
    drive(4'h1, 1'b0, 1'b0);
    run(28);
    chk("reach_note7", 2'd2, 6'd7, 1'b1, 2'd1, 1'b1);
    drive(4'h1, 1'b0, 1'b0);
    chk("pause_note7", 2'd2, 6'd7, 1'b0, 2'd2, 1'b0);
    drive(4'h1, 1'b0, 1'b1);
    chk("rst_in_pause", 2'd0, 6'd0, 1'b0, 2'd0, 1'b0);
    drive(4'h0, 1'b0, 1'b0);
    chk("rst_no_key_kept", 2'd0, 6'd0, 1'b0, 2'd0, 1'b0);

    // End-of-song by reaching the last address 63 without note_end.
    drive(4'h1, 1'b0, 1'b0);
    chk("play_song0", 2'd0, 6'd0, 1'b1, 2'd1, 1'b0);
    run(252);
    chk("reach_note63", 2'd0, 6'd63, 1'b1, 2'd1, 1'b1);
    run(3);
    drive(4'h0, 1'b0, 1'b0);
    if (AUTO) chk("max_end_auto", 2'd1, 6'd0, 1'b1, 2'd1, 1'b1);
    else      chk("max_end_idle", 2'd0, 6'd0, 1'b0, 2'd0, 1'b1);
    drive(4'h0, 1'b0, 1'b0);
    if (AUTO) chk("after_end_auto", 2'd1, 6'd0, 1'b1, 2'd1, 1'b0);
    else      chk("after_end_idle", 2'd0, 6'd0, 1'b0, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
